// File: rtl/if_id_stage.sv
// IF stage PC register and IF/ID pipeline register with stall and redirect handling.
// Optional performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
`ifdef IF_ID_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  output logic        id_valid
);

  typedef enum logic [1:0] {
    ACT_FETCH,
    ACT_HOLD,
    ACT_REDIRECT
  } action_t;

  action_t     action;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // Stall outranks any redirect; jump outranks branch when both are raised.
  always_comb begin
    action      = ACT_FETCH;
    redirect_pc = branch_target;
    if (stall) begin
      action = ACT_HOLD;
    end else if (jump) begin
      action      = ACT_REDIRECT;
      redirect_pc = jump_target;
    end else if (branch_taken) begin
      action = ACT_REDIRECT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc4   <= '0;
      id_valid <= 1'b0;
    end else begin
      case (action)
        ACT_HOLD: begin
          pc       <= pc;
          id_instr <= id_instr;
          id_pc4   <= id_pc4;
          id_valid <= id_valid;
        end
        ACT_REDIRECT: begin
          pc       <= redirect_pc;
          id_instr <= NOP_INSTR;
          id_pc4   <= '0;
          id_valid <= 1'b0;
        end
        default: begin
          pc       <= pc_plus4;
          id_instr <= imem_rdata;
          id_pc4   <= pc_plus4;
          id_valid <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (action == ACT_HOLD && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (action == ACT_REDIRECT && flush_cnt != '1)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage; counter checks follow IF_ID_PERF_CNT_EN.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instruction memory: fixed word at 0, otherwise address XOR 0x1234_0000.
  assign imem_rdata = (imem_addr == 32'h0) ? 32'h8C01_0004 : (imem_addr ^ 32'h1234_0000);

  if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_instr(id_instr), .id_pc4(id_pc4),
`ifdef IF_ID_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .id_valid(id_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic v);
    chk({tag, ".pc"}, imem_addr, pc);
    chk({tag, ".instr"}, id_instr, ins);
    chk({tag, ".pc4"}, id_pc4, pc4);
    chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, v});
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] s, input logic [31:0] f);
`ifdef IF_ID_PERF_CNT_EN
    chk({tag, ".stall_cnt"}, stall_cnt, s);
    chk({tag, ".flush_cnt"}, flush_cnt, f);
`endif
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    #1;
    chk_if("reset_async", 32'h0, NOP, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk_if("reset", 32'h0, NOP, 32'h0, 1'b0);
    chk_cnt("reset", 32'd0, 32'd0);
    rst = 1'b0;

    // Free-running fetch from RESET_PC.
    step; chk_if("fetch1", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    step; chk_if("fetch2", 32'h8, 32'h1234_0004, 32'h8, 1'b1);
    step; chk_if("fetch3", 32'hC, 32'h1234_0008, 32'hC, 1'b1);
    step; chk_if("fetch4", 32'h10, 32'h1234_000C, 32'h10, 1'b1);

    // Two stalled cycles at pc 0x10, then release.
    stall = 1'b1;
    step; chk_if("stall1", 32'h10, 32'h1234_000C, 32'h10, 1'b1);
    step; chk_if("stall2", 32'h10, 32'h1234_000C, 32'h10, 1'b1);
    chk_cnt("stall2", 32'd2, 32'd0);
    stall = 1'b0;
    step; chk_if("release", 32'h14, 32'h1234_0010, 32'h14, 1'b1);
    step; chk_if("fetch5", 32'h18, 32'h1234_0014, 32'h18, 1'b1);

    // Taken branch at pc 0x18.
    branch_taken = 1'b1; branch_target = 32'h40;
    step; chk_if("branch", 32'h40, NOP, 32'h0, 1'b0);
    chk_cnt("branch", 32'd2, 32'd1);

    // Jump, branch and stall together: stall wins, then jump beats branch.
    jump = 1'b1; jump_target = 32'h80; branch_target = 32'h100; stall = 1'b1;
    step; chk_if("all3_stall", 32'h40, NOP, 32'h0, 1'b0);
    chk_cnt("all3_stall", 32'd3, 32'd1);
    stall = 1'b0;
    step; chk_if("jump_prio", 32'h80, NOP, 32'h0, 1'b0);
    chk_cnt("jump_prio", 32'd3, 32'd2);
    jump = 1'b0; branch_taken = 1'b0;
    step; chk_if("fetch6", 32'h84, 32'h1234_0080, 32'h84, 1'b1);

    // PC wrap at the top of the address space.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step; chk_if("jump_top", 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
    jump = 1'b0;
    step; chk_if("wrap", 32'h0, 32'hEDCB_FFFC, 32'h0, 1'b1);

    // Unaligned target passes through untouched.
    branch_taken = 1'b1; branch_target = 32'h103;
    step; chk_if("unaligned", 32'h103, NOP, 32'h0, 1'b0);
    chk_cnt("unaligned", 32'd3, 32'd4);
    branch_taken = 1'b0;
    step; chk_if("fetch7", 32'h107, 32'h1234_0103, 32'h107, 1'b1);

    // Reset mid-cycle during a stall takes effect before the next edge.
    stall = 1'b1;
    step; chk_if("pre_rst_stall", 32'h107, 32'h1234_0103, 32'h107, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_if("rst_mid_stall", 32'h0, NOP, 32'h0, 1'b0);
    chk_cnt("rst_mid_stall", 32'd0, 32'd0);
    step; chk_if("rst_held", 32'h0, NOP, 32'h0, 1'b0);
    rst = 1'b0; stall = 1'b0;
    step; chk_if("post_rst", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);
    chk_cnt("post_rst", 32'd0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word injected as a bubble.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port stall, input, 1, from hazard detection: hold PC and IF/ID register.
REQ-006 SHALL have port branch_taken, input, 1, taken beq/bne resolved in ID.
REQ-007 SHALL have port branch_target, input, 32, branch destination address.
REQ-008 SHALL have port jump, input, 1, j/jal decoded in ID.
REQ-009 SHALL have port jump_target, input, 32, jump destination address.
REQ-010 SHALL have port imem_addr, output, 32, instruction memory address, equal to current PC.
REQ-011 SHALL have port imem_rdata, input, 32, instruction word; combinational read of imem_addr.
REQ-012 SHALL have port id_instr, output, 32, registered instruction presented to ID.
REQ-013 SHALL have port id_pc4, output, 32, registered PC+4 of id_instr.
REQ-014 SHALL have port id_valid, output, 1, high when id_instr is a real fetched instruction, low for a bubble.

Function
REQ-015 SHALL hold PC register pc; imem_addr = pc combinationally.
REQ-016 SHALL evaluate each edge with priority: rst > stall > jump > branch_taken > normal fetch.
REQ-017 SHALL on stall=1: pc, id_instr, id_pc4, id_valid all unchanged; jump/branch_taken ignored that cycle.
REQ-018 SHALL on jump=1 (stall=0): pc <= jump_target; id_instr <= NOP_INSTR; id_pc4 <= 0; id_valid <= 0.
REQ-019 SHALL on branch_taken=1, jump=0 (stall=0): pc <= branch_target; IF/ID loaded as in REQ-018.
REQ-020 SHALL on normal fetch: pc <= pc+4; id_instr <= imem_rdata; id_pc4 <= pc+4; id_valid <= 1.
REQ-021 SHALL compute pc+4 modulo 2^32; pc 32'hFFFF_FFFC wraps to 32'h0000_0000 without error.
REQ-022 SHALL use targets unmodified; the low two bits are not forced to zero.
REQ-023 SHALL have latency of one cycle from imem_addr to id_instr with no back-pressure beyond stall.
REQ-024 SHALL, when stall deasserts after N held cycles, resume with the same instruction in ID and the same pc; nothing is lost or duplicated.

Reset
REQ-025 SHALL on rst=1 asynchronously set pc=RESET_PC, id_instr=NOP_INSTR, id_pc4=0, id_valid=0.
REQ-026 SHALL, on the first edge after rst deasserts with stall=0, fetch from RESET_PC.
REQ-027 SHALL let rst asserted mid-stall or mid-redirect override all pending activity immediately.

Configuration
REQ-028 SHALL, when macro IF_ID_PERF_CNT_EN is defined, add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-029 SHALL increment stall_cnt once per edge with stall=1; flush_cnt once per edge applying REQ-018/019; both saturate at 32'hFFFF_FFFF; both reset to 0 with rst.
REQ-030 SHALL, when IF_ID_PERF_CNT_EN is undefined, omit both ports and counters; all other behaviour identical.

Verification
REQ-031 SHALL cover reset then 3 free-running cycles, imem returning 0x8C01_0004 at 0x0 -> imem_addr 0x0,0x4,0x8; id_instr 0x8C01_0004, id_pc4 0x4, id_valid=1 after first edge.
REQ-032 SHALL cover stall held 2 cycles at pc=0x10 -> pc stays 0x10, IF/ID unchanged, stall_cnt +2 when enabled; release -> pc 0x14.
REQ-033 SHALL cover branch_taken with target 0x40 at pc=0x18 -> next pc 0x40, id_instr=NOP_INSTR, id_valid=0, flush_cnt +1.
REQ-034 SHALL cover jump=1, branch_taken=1, stall=1 together -> no change; then stall=0 -> pc=jump_target, not branch_target.
REQ-035 SHALL cover pc 0xFFFF_FFFC normal fetch -> pc 0x0, id_pc4 0x0.
REQ-036 SHALL cover rst asserted mid-cycle during stall -> outputs reach reset values before next clk edge.
